// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer driving an external 1-bit full adder, LSB first.
// Latency WIDTH+1 cycles from start to done; start is ignored while busy or done, with no queuing.
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic             fa_a,
  output logic             fa_b,
  output logic             fa_ci,
  input  logic             fa_s,
  input  logic             fa_co,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             co
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sh, b_sh, sum_w, sum_nxt;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             last;

  // Sum bits enter at the MSB so the LSB-first result lands aligned after WIDTH shifts.
  generate
    if (WIDTH == 1) begin : g_w1
      assign sum_nxt = fa_s;
    end else begin : g_wn
      assign sum_nxt = {fa_s, sum_w[WIDTH-1:1]};
    end
  endgenerate

  assign last = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last)  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy  = (state == RUN);
  assign done  = (state == DONE);
  assign fa_a  = busy & a_sh[0];
  assign fa_b  = busy & b_sh[0];
  assign fa_ci = busy & carry;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh  <= '0;
      b_sh  <= '0;
      sum_w <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      s     <= '0;
      co    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sh  <= a;
            b_sh  <= b;
            carry <= ci;
            sum_w <= '0;
            cnt   <= '0;
          end
        end
        RUN: begin
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          sum_w <= sum_nxt;
          carry <= fa_co;
          cnt   <= cnt + 1'b1;
          // Results stay frozen until the final bit is produced.
          if (last) begin
            s  <= sum_nxt;
            co <= fa_co;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
